fp_vec_mult_dma: RTL and testbench

Avalon-MM master that streams operand pairs from memory into the floating-point multiplier peripheral and writes each product back to memory. It sits directly upstream of the FP multiplier peripheral on the system interconnect: it is the only agent that drives that peripheral's slave port during a job. A CPU-facing Avalon slave CSR port configures and launches jobs.

---
 rtl/fp_vec_mult_dma.sv | 201 ++++++++++++++++++++
 tb/tb_fp_vec_mult_dma.sv | 385 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_vec_mult_dma.sv
// fp_vec_mult_dma: Avalon-MM DMA master that feeds operand pairs from memory into the
// FP multiplier peripheral and writes each product back to memory.
// CPU-facing CSR slave (s1) configures and launches jobs; master (m1) does all traffic.
// Optional build macro: FPVM_STOP_ON_NAN_EN (abort the job after an element whose
// flags report NaN; STATUS bit2 records the abort).
module fp_vec_mult_dma (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  avs_s1_address,
    input  logic        avs_s1_read,
    input  logic        avs_s1_write,
    input  logic [31:0] avs_s1_writedata,
    output logic [31:0] avs_s1_readdata,
    output logic        avs_s1_waitrequest,
    output logic [31:0] avm_m1_address,
    output logic        avm_m1_read,
    output logic        avm_m1_write,
    output logic [31:0] avm_m1_writedata,
    input  logic [31:0] avm_m1_readdata,
    input  logic        avm_m1_waitrequest
);

    typedef enum logic [3:0] {
        StIdle, StRdA, StRdB, StWrOp1, StWrOp2, StWrGo, StRdRes, StRdFlg, StWrDst, StDone
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] src_a_q, src_b_q, dst_q, count_q, fpm_base_q;
    logic [31:0] idx_q, a_q, b_q, res_q;
    logic [31:0] readdata_q;
    logic [3:0]  flags_q;
    logic        busy_q, done_q, rd_pend_q;
    logic        go, last_elem, stop, aborted;
    logic [31:0] offset, csr_mux;

`ifdef FPVM_STOP_ON_NAN_EN
    logic abort_q;
    assign stop    = abort_q;
    assign aborted = abort_q;
`else
    assign stop    = 1'b0;
    assign aborted = 1'b0;
`endif

    // A go while busy is dropped, so go only qualifies when idle.
    assign go        = avs_s1_write && (avs_s1_address == 3'd4) && avs_s1_writedata[0] && !busy_q;
    assign last_elem = (idx_q + 32'd1) == count_q;
    assign offset    = {idx_q[29:0], 2'b00};

    // Master FSM state register.
    always_ff @(posedge clk) begin
        if (reset) state_q <= StIdle;
        else       state_q <= state_d;
    end

    // Next-state and master outputs; every bus state holds until waitrequest drops.
    always_comb begin
        state_d          = state_q;
        avm_m1_read      = 1'b0;
        avm_m1_write     = 1'b0;
        avm_m1_address   = 32'd0;
        avm_m1_writedata = 32'd0;
        case (state_q)
            StIdle: if (go) state_d = (count_q == 32'd0) ? StDone : StRdA;
            StRdA: begin
                avm_m1_read    = 1'b1;
                avm_m1_address = src_a_q + offset;
                if (!avm_m1_waitrequest) state_d = StRdB;
            end
            StRdB: begin
                avm_m1_read    = 1'b1;
                avm_m1_address = src_b_q + offset;
                if (!avm_m1_waitrequest) state_d = StWrOp1;
            end
            StWrOp1: begin
                avm_m1_write     = 1'b1;
                avm_m1_address   = fpm_base_q;
                avm_m1_writedata = a_q;
                if (!avm_m1_waitrequest) state_d = StWrOp2;
            end
            StWrOp2: begin
                avm_m1_write     = 1'b1;
                avm_m1_address   = fpm_base_q + 32'h4;
                avm_m1_writedata = b_q;
                if (!avm_m1_waitrequest) state_d = StWrGo;
            end
            StWrGo: begin
                avm_m1_write   = 1'b1;
                avm_m1_address = fpm_base_q + 32'h8;
                if (!avm_m1_waitrequest) state_d = StRdRes;
            end
            StRdRes: begin
                avm_m1_read    = 1'b1;
                avm_m1_address = fpm_base_q + 32'hC;
                if (!avm_m1_waitrequest) state_d = StRdFlg;
            end
            StRdFlg: begin
                avm_m1_read    = 1'b1;
                avm_m1_address = fpm_base_q + 32'h10;
                if (!avm_m1_waitrequest) state_d = StWrDst;
            end
            StWrDst: begin
                avm_m1_write     = 1'b1;
                avm_m1_address   = dst_q + offset;
                avm_m1_writedata = res_q;
                if (!avm_m1_waitrequest) state_d = (last_elem || stop) ? StDone : StRdA;
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // CSR registers, job status and datapath captures from the master port.
    always_ff @(posedge clk) begin
        if (reset) begin
            src_a_q    <= 32'd0;
            src_b_q    <= 32'd0;
            dst_q      <= 32'd0;
            count_q    <= 32'd0;
            fpm_base_q <= 32'd0;
            idx_q      <= 32'd0;
            a_q        <= 32'd0;
            b_q        <= 32'd0;
            res_q      <= 32'd0;
            flags_q    <= 4'd0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
`ifdef FPVM_STOP_ON_NAN_EN
            abort_q    <= 1'b0;
`endif
        end else begin
            if (avs_s1_write && !busy_q) begin
                case (avs_s1_address)
                    3'd0:    src_a_q    <= avs_s1_writedata;
                    3'd1:    src_b_q    <= avs_s1_writedata;
                    3'd2:    dst_q      <= avs_s1_writedata;
                    3'd3:    count_q    <= avs_s1_writedata;
                    3'd6:    fpm_base_q <= avs_s1_writedata;
                    default: ;
                endcase
            end
            if (go) begin
                busy_q  <= 1'b1;
                done_q  <= 1'b0;
                flags_q <= 4'd0;
                idx_q   <= 32'd0;
`ifdef FPVM_STOP_ON_NAN_EN
                abort_q <= 1'b0;
`endif
            end
            if (!avm_m1_waitrequest) begin
                case (state_q)
                    StRdA:   a_q   <= avm_m1_readdata;
                    StRdB:   b_q   <= avm_m1_readdata;
                    StRdRes: res_q <= avm_m1_readdata;
                    StRdFlg: begin
                        flags_q <= flags_q | avm_m1_readdata[3:0];
`ifdef FPVM_STOP_ON_NAN_EN
                        if (avm_m1_readdata[0]) abort_q <= 1'b1;
`endif
                    end
                    StWrDst: idx_q <= idx_q + 32'd1;
                    default: ;
                endcase
            end
            if (state_q == StDone) begin
                busy_q <= 1'b0;
                done_q <= 1'b1;
            end
        end
    end

    // CSR read mux, sampled in the first (stalled) read cycle.
    always_comb begin
        csr_mux = 32'd0;
        case (avs_s1_address)
            3'd0:    csr_mux = src_a_q;
            3'd1:    csr_mux = src_b_q;
            3'd2:    csr_mux = dst_q;
            3'd3:    csr_mux = count_q;
            3'd5:    csr_mux = {24'd0, flags_q, 1'b0, aborted, done_q, busy_q};
            3'd6:    csr_mux = fpm_base_q;
            default: csr_mux = 32'd0;
        endcase
    end

    // One-wait-state CSR read: register data in cycle 1, release waitrequest in cycle 2.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_pend_q  <= 1'b0;
            readdata_q <= 32'd0;
        end else begin
            rd_pend_q <= avs_s1_read && !rd_pend_q;
            if (avs_s1_read && !rd_pend_q) readdata_q <= csr_mux;
        end
    end

    assign avs_s1_readdata    = readdata_q;
    assign avs_s1_waitrequest = avs_s1_read && !rd_pend_q;

endmodule

// File: tb/tb_fp_vec_mult_dma.sv
// Bench for fp_vec_mult_dma: memory + FP multiplier peripheral model on the master port,
// random slave stalls, and a scoreboard of expected destination writes.
module tb_fp_vec_mult_dma;

    localparam logic [31:0] FPM = 32'hF000_0000;

    logic        clk, reset;
    logic [2:0]  avs_s1_address;
    logic        avs_s1_read, avs_s1_write;
    logic [31:0] avs_s1_writedata, avs_s1_readdata;
    logic        avs_s1_waitrequest;
    logic [31:0] avm_m1_address, avm_m1_writedata, avm_m1_readdata;
    logic        avm_m1_read, avm_m1_write, avm_m1_waitrequest;

    fp_vec_mult_dma dut (
        .clk                (clk),
        .reset              (reset),
        .avs_s1_address     (avs_s1_address),
        .avs_s1_read        (avs_s1_read),
        .avs_s1_write       (avs_s1_write),
        .avs_s1_writedata   (avs_s1_writedata),
        .avs_s1_readdata    (avs_s1_readdata),
        .avs_s1_waitrequest (avs_s1_waitrequest),
        .avm_m1_address     (avm_m1_address),
        .avm_m1_read        (avm_m1_read),
        .avm_m1_write       (avm_m1_write),
        .avm_m1_writedata   (avm_m1_writedata),
        .avm_m1_readdata    (avm_m1_readdata),
        .avm_m1_waitrequest (avm_m1_waitrequest)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    int          total = 0;
    int          bad = 0;
    int          txn_cnt = 0;
    int          dst_wr = 0;
    bit          rand_wait = 0;
    wr_t         exp_q[$];
    logic [31:0] mem [logic [31:0]];
    logic [31:0] va [8];
    logic [31:0] vb [8];
    logic [31:0] p_op1 = 0, p_op2 = 0, p_res = 0;
    logic [3:0]  p_flg = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, req);
        end
    endtask

    // Behavioural float multiply via real arithmetic (operands chosen so it is exact).
    function automatic real f2r(input logic [31:0] x);
        logic [63:0] b;
        int e;
        if (x[30:23] == 8'd0) return 0.0;
        e = int'(x[30:23]) + 896;
        b = {x[31], e[10:0], x[22:0], 29'd0};
        return $bitstoreal(b);
    endfunction

    function automatic logic [31:0] r2f(input real r);
        logic [63:0] b;
        int e;
        if (r == 0.0) return 32'd0;
        b = $realtobits(r);
        e = int'(b[62:52]) - 896;
        return {b[63], e[7:0], b[51:29]};
    endfunction

    // Returns {flags, product}; flags = {ovf, unf, zero, nan}.
    function automatic logic [35:0] fmul(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        if ((a[30:0] == 31'h7F800000 && b[30:0] == 31'd0) ||
            (b[30:0] == 31'h7F800000 && a[30:0] == 31'd0)) return {4'b0001, 32'h7FC00000};
        r = r2f(f2r(a) * f2r(b));
        if (r[30:0] == 31'd0) return {4'b0010, r};
        return {4'b0000, r};
    endfunction

    function automatic logic [31:0] rand_fp();
        logic [31:0] v;
        v = {1'($urandom_range(0, 1)), 8'($urandom_range(110, 140)), 8'($urandom), 15'd0};
        return v;
    endfunction

    // Slave model: memory + FPM peripheral, random stalls, stall-stability checks.
    initial begin
        logic [31:0] s_addr, s_data;
        logic        s_rd, s_wr;
        logic [35:0] fr;
        bit          in_txn;
        int          wl;
        in_txn = 0;
        wl = 0;
        avm_m1_waitrequest = 1'b0;
        avm_m1_readdata = 32'd0;
        forever begin
            @(posedge clk);
            #1;
            if (!(avm_m1_read || avm_m1_write)) begin
                in_txn = 0;
                avm_m1_waitrequest = 1'b0;
            end else begin
                if (avm_m1_read && avm_m1_write) begin
                    total++;
                    bad++;
                    $display("FAIL two_strobes: got rd=1 wr=1 want one strobe");
                end
                if (!in_txn) begin
                    in_txn = 1;
                    s_addr = avm_m1_address;
                    s_data = avm_m1_writedata;
                    s_rd = avm_m1_read;
                    s_wr = avm_m1_write;
                    wl = rand_wait ? int'($urandom_range(0, 3)) : 0;
                    if (avm_m1_read && avm_m1_address == FPM + 32'hC) wl += 2;
                end else begin
                    total++;
                    if ({avm_m1_address, avm_m1_writedata, avm_m1_read, avm_m1_write} !==
                        {s_addr, s_data, s_rd, s_wr}) begin
                        bad++;
                        $display("FAIL stall_stable: got %h/%h/%b%b want %h/%h/%b%b",
                                 avm_m1_address, avm_m1_writedata, avm_m1_read, avm_m1_write,
                                 s_addr, s_data, s_rd, s_wr);
                    end
                end
                if (wl > 0) begin
                    wl--;
                    avm_m1_waitrequest = 1'b1;
                end else begin
                    avm_m1_waitrequest = 1'b0;
                    in_txn = 0;
                    txn_cnt++;
                    if (s_addr >= FPM && s_addr < FPM + 32'h14) begin
                        case (s_addr - FPM)
                            32'h0:  if (s_wr) p_op1 = s_data;
                            32'h4:  if (s_wr) p_op2 = s_data;
                            32'h8:  if (s_wr) begin fr = fmul(p_op1, p_op2); {p_flg, p_res} = fr; end
                            32'hC:  if (s_rd) avm_m1_readdata = p_res;
                            32'h10: if (s_rd) avm_m1_readdata = {28'd0, p_flg};
                            default: ;
                        endcase
                    end else if (s_wr) begin
                        mem[s_addr] = s_data;
                        dst_wr++;
                    end else begin
                        avm_m1_readdata = mem.exists(s_addr) ? mem[s_addr] : 32'd0;
                    end
                end
            end
        end
    end

    // Scoreboard monitor: each accepted memory write is popped against the expected queue.
    always @(negedge clk) begin
        if (!reset && avm_m1_write && !avm_m1_waitrequest &&
            !(avm_m1_address >= FPM && avm_m1_address < FPM + 32'h14)) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL dst_unexpected: got %h@%h want none", avm_m1_writedata,
                         avm_m1_address);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                if (avm_m1_address !== e.addr || avm_m1_writedata !== e.data) begin
                    bad++;
                    $display("FAIL dst_write: got %h@%h want %h@%h", avm_m1_writedata,
                             avm_m1_address, e.data, e.addr);
                end
            end
        end
    end

    task automatic csr_wr(input logic [2:0] a, input logic [31:0] d);
        avs_s1_address = a;
        avs_s1_writedata = d;
        avs_s1_write = 1'b1;
        @(posedge clk);
        #1;
        avs_s1_write = 1'b0;
    endtask

    task automatic csr_rd(input logic [2:0] a, output logic [31:0] d);
        avs_s1_address = a;
        avs_s1_read = 1'b1;
        #1;
        check("csr_wait1", {31'd0, avs_s1_waitrequest}, 32'd1);
        @(posedge clk);
        #1;
        check("csr_wait2", {31'd0, avs_s1_waitrequest}, 32'd0);
        d = avs_s1_readdata;
        @(posedge clk);
        #1;
        avs_s1_read = 1'b0;
    endtask

    // Loads memory, pushes the model's expected writes, programs CSRs and issues go.
    task automatic launch(input logic [31:0] sa, input logic [31:0] sb, input logic [31:0] d,
                          input int n, input bit push, output logic [31:0] est,
                          output int n_exp);
        logic [35:0] fr;
        wr_t w;
        est = 32'h2;
        n_exp = n;
        for (int i = 0; i < n; i++) begin
            mem[sa + 32'(4 * i)] = va[i];
            mem[sb + 32'(4 * i)] = vb[i];
        end
        for (int i = 0; i < n; i++) begin
            fr = fmul(va[i], vb[i]);
            est[7:4] = est[7:4] | fr[35:32];
            w.addr = d + 32'(4 * i);
            w.data = fr[31:0];
            if (push) exp_q.push_back(w);
`ifdef FPVM_STOP_ON_NAN_EN
            if (fr[32]) begin
                est[2] = 1'b1;
                n_exp = i + 1;
                break;
            end
`endif
        end
        csr_wr(3'd0, sa);
        csr_wr(3'd1, sb);
        csr_wr(3'd2, d);
        csr_wr(3'd3, 32'(n));
        csr_wr(3'd6, FPM);
        csr_wr(3'd4, 32'd1);
    endtask

    task automatic wait_idle(output logic [31:0] st);
        bit ok;
        ok = 0;
        st = 32'hFFFF_FFFF;
        for (int k = 0; k < 400; k++) begin
            csr_rd(3'd5, st);
            if (!st[0]) begin
                ok = 1;
                break;
            end
        end
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL job_timeout: got busy want idle");
        end
    endtask

    initial begin
        logic [31:0] st, est, rd;
        int n_exp;
        bit found;
        reset = 1'b1;
        avs_s1_address = 3'd0;
        avs_s1_read = 1'b0;
        avs_s1_write = 1'b0;
        avs_s1_writedata = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_strobes", {30'd0, avm_m1_read, avm_m1_write}, 32'd0);
        check("rst_addr", avm_m1_address, 32'd0);
        check("rst_wdata", avm_m1_writedata, 32'd0);
        check("rst_rdata", avs_s1_readdata, 32'd0);
        check("rst_swait", {31'd0, avs_s1_waitrequest}, 32'd0);
        reset = 1'b0;
        csr_rd(3'd5, st);
        check("rst_status", st, 32'd0);

        // Single element 2.0 * 3.0.
        va[0] = 32'h40000000;
        vb[0] = 32'h40400000;
        txn_cnt = 0;
        launch(32'h1000, 32'h2000, 32'h3000, 1, 1, est, n_exp);
        wait_idle(st);
        check("single_status", st, 32'h2);
        check("single_txns", 32'(txn_cnt), 32'd8);
        check("single_mem", mem[32'h3000], 32'h40C00000);

        // Random four-element jobs with random stalls, the last one wrapping SRC_A.
        rand_wait = 1;
        for (int it = 0; it < 4; it++) begin
            for (int i = 0; i < 4; i++) begin
                va[i] = rand_fp();
                vb[i] = rand_fp();
            end
            txn_cnt = 0;
            launch((it == 3) ? 32'hFFFF_FFF8 : 32'h1_0000 + 32'(it * 256),
                   32'h2_0000 + 32'(it * 256), 32'h3_0000 + 32'(it * 256), 4, 1, est, n_exp);
            wait_idle(st);
            check("rand_status", st, est);
            check("rand_txns", 32'(txn_cnt), 32'd32);
        end

        // COUNT = 0: no traffic, done within two cycles.
        rand_wait = 0;
        txn_cnt = 0;
        launch(32'h1000, 32'h2000, 32'h3000, 0, 1, est, n_exp);
        @(posedge clk);
        #1;
        csr_rd(3'd5, st);
        check("cnt0_status", st, 32'h2);
        check("cnt0_txns", 32'(txn_cnt), 32'd0);

        // NaN product at element 1 of 3.
        rand_wait = 1;
        va[0] = rand_fp();
        vb[0] = rand_fp();
        va[1] = 32'h7F800000;
        vb[1] = 32'h00000000;
        va[2] = rand_fp();
        vb[2] = rand_fp();
        txn_cnt = 0;
        dst_wr = 0;
        launch(32'h4000, 32'h5000, 32'h6000, 3, 1, est, n_exp);
        wait_idle(st);
        check("nan_status", st, est);
        check("nan_dst_writes", 32'(dst_wr), 32'(n_exp));
        check("nan_txns", 32'(txn_cnt), 32'(8 * n_exp));

        // CSR write and second go while busy must have no effect.
        for (int i = 0; i < 4; i++) begin
            va[i] = rand_fp();
            vb[i] = rand_fp();
        end
        launch(32'h7000, 32'h8000, 32'h9000, 4, 1, est, n_exp);
        csr_wr(3'd0, 32'hDEAD_0000);
        csr_wr(3'd4, 32'd1);
        wait_idle(st);
        check("busy_status", st, 32'h2);
        csr_rd(3'd0, rd);
        check("busy_src_a", rd, 32'h7000);

        // Reset while stalled in the result read.
        rand_wait = 0;
        va[0] = rand_fp();
        vb[0] = rand_fp();
        va[1] = rand_fp();
        vb[1] = rand_fp();
        launch(32'hA000, 32'hB000, 32'hC000, 2, 0, est, n_exp);
        found = 0;
        for (int k = 0; k < 100; k++) begin
            if (avm_m1_read && avm_m1_address == FPM + 32'hC) begin
                found = 1;
                break;
            end
            @(posedge clk);
            #1;
        end
        if (!found) begin
            total++;
            bad++;
            $display("FAIL rdres_timeout: got no result read want one");
        end
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("midrst_strobes", {30'd0, avm_m1_read, avm_m1_write}, 32'd0);
        for (int a = 0; a < 8; a++) begin
            csr_rd(3'(a), rd);
            check("midrst_csr", rd, 32'd0);
        end
        va[0] = rand_fp();
        vb[0] = rand_fp();
        launch(32'hD000, 32'hE000, 32'hF000, 1, 1, est, n_exp);
        wait_idle(st);
        check("post_rst_status", st, 32'h2);

        repeat (3) @(posedge clk);
        check("exp_q_empty", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
